// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder slice per clock, LSB first.
// Operand pair enters over a valid/ready handshake; sum and carry-out leave over a second one.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready=1
  // RUN   | one bit slice per cycle, exactly WIDTH cycles
  // DONE  | result presented, out_valid=1 until out_ready
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_carry_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nxt;

  assign w_s         = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
  assign w_carry_nxt = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
  assign w_last      = (r_cnt == LAST);

  // Only the upper WIDTH-1 collected bits need storage; the newest bit joins on the final edge.
  generate
    if (WIDTH == 1) begin : g_one
      assign w_sum_nxt = w_s;
    end else begin : g_multi
      logic [WIDTH-2:0] r_sum_sr;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sum_sr <= '0;
        end else if (r_state == S_RUN) begin
          r_sum_sr <= w_sum_nxt[WIDTH-1:1];
        end
      end
      assign w_sum_nxt = {w_s, r_sum_sr};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= w_sum_nxt;
            r_cout <= w_carry_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 instance driven from a vector table and corner sequences,
// WIDTH=1 instance for back-to-back operation.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;

  int n_cmp = 0;
  int n_mis = 0;

  logic [8:0] sb8[$];
  logic [1:0] sb1[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    int         stall;
  } vec_t;

  vec_t vecs[7];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input logic [7:0] es, input logic ec, input int stall,
                      input bit garble, input string nm);
    logic [8:0] exp;
    int lat;
    @(negedge clk);
    chk({nm, ".in_ready"}, 64'(in_ready8), 64'd1);
    a8 = ta; b8 = tb_v; cin8 = tc; in_valid8 = 1'b1;
    sb8.push_back({ec, es});
    @(posedge clk); #1;
    in_valid8 = garble;
    a8 = 8'h0F; b8 = 8'hF0; cin8 = ~tc;
    lat = 0;
    while (out_valid8 !== 1'b1 && lat < 32) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid8 = 1'b0;
    chk({nm, ".latency"}, 64'(lat), 64'd8);
    exp = sb8.pop_front();
    chk({nm, ".sum"}, 64'(sum8), 64'(exp[7:0]));
    chk({nm, ".cout"}, 64'(cout8), 64'(exp[8]));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({nm, ".hold_valid"}, 64'(out_valid8), 64'd1);
      chk({nm, ".hold_in_ready"}, 64'(in_ready8), 64'd0);
      chk({nm, ".hold_sum"}, 64'(sum8), 64'(exp[7:0]));
      chk({nm, ".hold_cout"}, 64'(cout8), 64'(exp[8]));
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk({nm, ".post_valid"}, 64'(out_valid8), 64'd0);
    chk({nm, ".post_in_ready"}, 64'(in_ready8), 64'd1);
    if (garble) begin
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        chk({nm, ".no_extra_valid"}, 64'(out_valid8), 64'd0);
      end
    end
  endtask

  initial begin
    logic [1:0] e1;
    vecs[0] = '{a: 8'd100, b: 8'd55,  cin: 1'b0, sum: 8'd155, cout: 1'b0, stall: 0};
    vecs[1] = '{a: 8'hFF,  b: 8'h01,  cin: 1'b0, sum: 8'h00,  cout: 1'b1, stall: 0};
    vecs[2] = '{a: 8'hFF,  b: 8'hFF,  cin: 1'b1, sum: 8'hFF,  cout: 1'b1, stall: 5};
    vecs[3] = '{a: 8'h00,  b: 8'h00,  cin: 1'b1, sum: 8'h01,  cout: 1'b0, stall: 0};
    vecs[4] = '{a: 8'hAA,  b: 8'h55,  cin: 1'b0, sum: 8'hFF,  cout: 1'b0, stall: 2};
    vecs[5] = '{a: 8'h80,  b: 8'h80,  cin: 1'b0, sum: 8'h00,  cout: 1'b1, stall: 0};
    vecs[6] = '{a: 8'h3C,  b: 8'h5A,  cin: 1'b1, sum: 8'h97,  cout: 1'b0, stall: 1};

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready8), 64'd1);
    chk("rst.out_valid", 64'(out_valid8), 64'd0);
    chk("rst.sum", 64'(sum8), 64'd0);
    chk("rst.cout", 64'(cout8), 64'd0);
    chk("rst.w1_in_ready", 64'(in_ready1), 64'd1);

    for (int i = 0; i < 7; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
           vecs[i].stall, 1'b0, $sformatf("vec%0d", i));
    end

    run8(8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 0, 1'b1, "ignore_in");

    // Abort in the third RUN cycle; the stale result (7) must be cleared by reset.
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100; cin8 = 1'b0; in_valid8 = 1'b1;
    sb8.push_back(9'd300);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.running", 64'(out_valid8), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb8.pop_back());
    chk("abort.in_ready", 64'(in_ready8), 64'd1);
    chk("abort.out_valid", 64'(out_valid8), 64'd0);
    chk("abort.sum", 64'(sum8), 64'd0);
    chk("abort.cout", 64'(cout8), 64'd0);
    run8(8'd1, 8'd1, 1'b1, 8'd3, 1'b0, 0, 1'b0, "after_abort");

    // WIDTH=1 back-to-back: second operand held valid through DONE, accepted 3 cycles later.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    sb1.push_back(2'b11);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("w1.run_valid", 64'(out_valid1), 64'd0);
    chk("w1.run_in_ready", 64'(in_ready1), 64'd0);
    @(posedge clk); #1;
    chk("w1.op1_valid", 64'(out_valid1), 64'd1);
    e1 = sb1.pop_front();
    chk("w1.op1_sum", 64'(sum1), 64'(e1[0]));
    chk("w1.op1_cout", 64'(cout1), 64'(e1[1]));
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("w1.idle_in_ready", 64'(in_ready1), 64'd1);
    chk("w1.idle_valid", 64'(out_valid1), 64'd0);
    chk("w1.idle_sum_held", 64'(sum1), 64'd1);
    sb1.push_back(2'b01);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("w1.op2_accepted", 64'(in_ready1), 64'd0);
    @(posedge clk); #1;
    chk("w1.op2_valid", 64'(out_valid1), 64'd1);
    e1 = sb1.pop_front();
    chk("w1.op2_sum", 64'(sum1), 64'(e1[0]));
    chk("w1.op2_cout", 64'(cout1), 64'(e1[1]));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("w1.end_in_ready", 64'(in_ready1), 64'd1);

    chk("sb8.empty", 64'(sb8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder built around the single-bit full-adder equation; one operand bit pair is processed per clock, LSB first.
- The carry is kept in a register between bit slices.
- Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake. Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits in the arithmetic datapath as the sequential wrapper that feeds bit slices to the combinational full-adder logic and assembles its sum/carry results.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair and cin are valid.
- in_ready  output  1  block can accept an operand pair.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset: synchronous, sampled on the rising clk edge while rst=1; overrides all other inputs.
  - After reset: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, bit counter=0, carry register=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On an edge with in_valid=1, load a and b into shift registers, carry<=cin, counter<=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - s = a_sr[0] ^ b_sr[0] ^ carry.
  - carry <= (a_sr[0]&b_sr[0]) | (a_sr[0]&carry) | (b_sr[0]&carry).
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one.
  - counter increments.
  - On the edge where counter==WIDTH-1, go to DONE. On that edge, sum takes the fully shifted value and cout takes the new carry.
- RUN lasts exactly WIDTH cycles. If the accept edge is edge k, out_valid is first high after edge k+WIDTH.
- DONE:
  - sum and cout hold stable while out_ready=0, for any number of cycles.
  - On an edge with out_ready=1, go to IDLE; in_ready rises on the following cycle.
  - No same-cycle accept of a new operand in DONE. Minimum period between accepts is WIDTH+2 cycles.
- in_valid, a, b and cin are ignored outside IDLE and are sampled only on the accept edge. Later changes to them do not affect an operation in flight.
- out_ready is ignored outside DONE.
- sum/cout are updated only on the RUN->DONE transition. They retain the last result through IDLE and the next RUN; consumers qualify them with out_valid.
- WIDTH=1: RUN lasts one cycle; the counter is at least 1 bit wide.
- Counter width is $clog2(WIDTH)+1.
- Wrap-around: overflow is reported only through cout; sum wraps modulo 2^WIDTH.
- Reset mid-RUN or mid-DONE:
  - Aborts the operation; no result is presented.
  - Outputs return to their reset values on the next edge.
  - The block accepts a new operand pair starting the cycle after reset deasserts.

Test Plan:
1. Basic add, WIDTH=8: a=100, b=55, cin=0 -> out_valid exactly 8 cycles after the accept edge; sum=155, cout=0.
2. Overflow: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Also a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
3. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> sum, cout and out_valid stay stable and in_ready stays 0. Raise out_ready -> IDLE next edge, in_ready=1.
4. Ignored input: pulse in_valid with a=8'h0F during RUN of a=3, b=4 -> result is sum=7. The second pair is not captured, and there is no extra out_valid.
5. Reset mid-operation: assert rst at RUN cycle 3 of a=200, b=100 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0. A new op a=1, b=1, cin=1 then yields sum=3.
6. Back-to-back with WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1 one cycle after accept. Then immediately a=0, b=0, cin=1 -> sum=1, cout=0. Confirm a minimum of 3 cycles between accepts.
